reg_file_sb: RTL and testbench

//  Parametrised multi-read-port register file with write-to-read bypass and a per-register

---
 rtl/reg_file_pkg.sv | 15 +
 rtl/reg_file_rd_port.sv | 45 ++++
 rtl/reg_file_sb.sv | 106 ++++++++++
 tb/tb_reg_file_sb.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults and helpers
// for the decode-stage register file slice.
package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  function automatic int slice_off(
    input int p,
    input int w
  );
    return p * w;
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port: one combinational read
// port with zero-reg mask and write bypass.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int DEPTH    = 2 ** ADDR_W
) (
  input  logic [DEPTH-1:0][DATA_W-1:0] mem,
  input  logic [DEPTH-1:0]             busy,
  input  logic [ADDR_W-1:0]            rd_addr,
  input  logic                         wr_ok,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         rd_busy
);

  logic hit;
  logic is_zero;

  assign hit     = (BYPASS != 0) && wr_ok
                && (wr_addr == rd_addr);
  assign is_zero = (ZERO_REG != 0)
                && (rd_addr == '0);

  // Stored value, overridden by a same-cycle
  // writeback, then masked for register 0.
  always_comb begin
    rd_data = mem[rd_addr];
    rd_busy = busy[rd_addr];
    if (hit) begin
      rd_data = wr_data;
      rd_busy = 1'b0;
    end
    if (is_zero) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port register file with
// write bypass and a busy scoreboard.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] ONE = 1;

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [DEPTH-1:0]             busy;
  logic [DEPTH-1:0]             busy_nxt;
  logic [ADDR_W:0]              cnt_nxt;
  logic                         wr_ok;
  logic                         iss_ok;
  logic                         set_inc;
  logic                         clr_dec;

  assign wr_ok  = wr_en && !((ZERO_REG != 0)
               && (wr_addr == '0));
  assign iss_ok = issue_en && !((ZERO_REG != 0)
               && (issue_addr == '0));

  // Issue sets busy and beats a same-cycle
  // writeback clear of the same register.
  always_comb begin
    busy_nxt = busy;
    for (int r = 0; r < DEPTH; r++) begin
      if (iss_ok && issue_addr == ADDR_W'(r))
        busy_nxt[r] = 1'b1;
      else if (wr_ok && wr_addr == ADDR_W'(r))
        busy_nxt[r] = 1'b0;
    end
  end

  // Running popcount: only real 0->1 and 1->0
  // transitions move the counter.
  always_comb begin
    set_inc = iss_ok && !busy[issue_addr];
    clr_dec = wr_ok && busy[wr_addr]
           && !(iss_ok && issue_addr == wr_addr);
    cnt_nxt = busy_cnt;
    unique case ({set_inc, clr_dec})
      2'b10:   cnt_nxt = busy_cnt + ONE;
      2'b01:   cnt_nxt = busy_cnt - ONE;
      default: cnt_nxt = busy_cnt;
    endcase
  end

  // Storage write; reset clears all contents.
  always_ff @(posedge clk) begin
    if (rst)
      mem <= '0;
    else if (wr_ok)
      mem[wr_addr] <= wr_data;
  end

  // Scoreboard and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    reg_file_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG),
      .DEPTH    (DEPTH)
    ) u_rd (
      .mem     (mem),
      .busy    (busy),
      .rd_addr (rd_addr[slice_off(p, ADDR_W) +: ADDR_W]),
      .wr_ok   (wr_ok),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_data (rd_data[slice_off(p, DATA_W) +: DATA_W]),
      .rd_busy (rd_busy[p])
    );
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed self-checking bench
// for reg_file_sb (BYPASS=1, ZERO_REG=1).
module tb_reg_file_sb;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic [5:0]  busy_cnt;

  int checks;
  int failures;

  reg_file_sb #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .NUM_RD   (2),
    .BYPASS   (1),
    .ZERO_REG (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .busy_cnt   (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(
    input logic [4:0] a0,
    input logic [4:0] a1
  );
    rd_addr = {a1, a0};
    #1;
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    issue_en = 1'b0;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    rd_addr    = '0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    issue_en   = 1'b0;
    issue_addr = '0;

    // 1. reset, then scan every address
    tick();
    tick();
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rd(5'(a), 5'(31 - a));
      chk($sformatf("rst_d0_%0d", a),
          64'(rd_data[31:0]), 64'h0);
      chk($sformatf("rst_d1_%0d", a),
          64'(rd_data[63:32]), 64'h0);
      chk($sformatf("rst_b_%0d", a),
          64'(rd_busy), 64'h0);
    end
    chk("rst_cnt", 64'(busy_cnt), 64'd0);

    // 2. write bypass r5
    wr_en   = 1'b1;
    wr_addr = 5'd5;
    wr_data = 32'hDEADBEEF;
    rd(5'd5, 5'd0);
    chk("byp_d0", 64'(rd_data[31:0]),
        64'hDEADBEEF);
    tick();
    idle();
    rd(5'd5, 5'd5);
    chk("st_d0", 64'(rd_data[31:0]),
        64'hDEADBEEF);
    chk("st_d1", 64'(rd_data[63:32]),
        64'hDEADBEEF);

    // 3. issue r7, then writeback r7
    issue_en   = 1'b1;
    issue_addr = 5'd7;
    tick();
    idle();
    rd(5'd5, 5'd7);
    chk("iss7_b", 64'(rd_busy), 64'b10);
    chk("iss7_cnt", 64'(busy_cnt), 64'd1);
    wr_en   = 1'b1;
    wr_addr = 5'd7;
    wr_data = 32'h12;
    rd(5'd5, 5'd7);
    chk("wb7_b", 64'(rd_busy), 64'b00);
    chk("wb7_d1", 64'(rd_data[63:32]),
        64'h12);
    chk("wb7_cnt_hold", 64'(busy_cnt), 64'd1);
    tick();
    idle();
    rd(5'd5, 5'd7);
    chk("wb7_cnt", 64'(busy_cnt), 64'd0);
    chk("wb7_b2", 64'(rd_busy), 64'b00);
    chk("wb7_d2", 64'(rd_data[63:32]),
        64'h12);

    // 4. issue+write same register
    issue_en   = 1'b1;
    issue_addr = 5'd9;
    tick();
    idle();
    chk("iss9_cnt", 64'(busy_cnt), 64'd1);
    issue_en   = 1'b1;
    issue_addr = 5'd9;
    wr_en      = 1'b1;
    wr_addr    = 5'd9;
    wr_data    = 32'h55;
    rd(5'd9, 5'd9);
    chk("rep9_byp_d", 64'(rd_data[31:0]),
        64'h55);
    chk("rep9_byp_b", 64'(rd_busy), 64'b00);
    tick();
    idle();
    rd(5'd9, 5'd9);
    chk("rep9_b", 64'(rd_busy), 64'b11);
    chk("rep9_d", 64'(rd_data[31:0]),
        64'h55);
    chk("rep9_cnt", 64'(busy_cnt), 64'd1);
    wr_en   = 1'b1;
    wr_addr = 5'd9;
    wr_data = 32'h66;
    tick();
    idle();
    rd(5'd9, 5'd7);
    chk("clr9_b", 64'(rd_busy), 64'b00);
    chk("clr9_d", 64'(rd_data[31:0]),
        64'h66);
    chk("clr9_cnt", 64'(busy_cnt), 64'd0);

    // 4b. set and clear on different regs
    issue_en   = 1'b1;
    issue_addr = 5'd4;
    tick();
    issue_addr = 5'd3;
    wr_en      = 1'b1;
    wr_addr    = 5'd4;
    wr_data    = 32'h44;
    tick();
    idle();
    rd(5'd3, 5'd4);
    chk("net0_cnt", 64'(busy_cnt), 64'd1);
    chk("net0_b", 64'(rd_busy), 64'b01);
    issue_en   = 1'b1;
    issue_addr = 5'd3;
    tick();
    idle();
    rd(5'd3, 5'd4);
    chk("reiss_cnt", 64'(busy_cnt), 64'd1);
    chk("reiss_b", 64'(rd_busy), 64'b01);
    wr_en   = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'h33;
    tick();
    idle();
    chk("clr3_cnt", 64'(busy_cnt), 64'd0);

    // 5. register zero
    wr_en      = 1'b1;
    wr_addr    = 5'd0;
    wr_data    = 32'hFFFF_FFFF;
    issue_en   = 1'b1;
    issue_addr = 5'd0;
    rd(5'd0, 5'd0);
    chk("z_byp_d", rd_data, 64'h0);
    chk("z_byp_b", 64'(rd_busy), 64'b00);
    tick();
    idle();
    rd(5'd0, 5'd0);
    chk("z_d", rd_data, 64'h0);
    chk("z_b", 64'(rd_busy), 64'b00);
    chk("z_cnt", 64'(busy_cnt), 64'd0);

    // 6a. reset mid issue sequence
    for (int r = 1; r <= 10; r++) begin
      issue_en   = 1'b1;
      issue_addr = 5'(r);
      tick();
    end
    idle();
    chk("seq10_cnt", 64'(busy_cnt), 64'd10);
    rst        = 1'b1;
    issue_en   = 1'b1;
    issue_addr = 5'd11;
    wr_en      = 1'b1;
    wr_addr    = 5'd12;
    wr_data    = 32'hABCD;
    tick();
    rst = 1'b0;
    idle();
    chk("mrst_cnt", 64'(busy_cnt), 64'd0);
    rd(5'd5, 5'd9);
    chk("mrst_d", rd_data, 64'h0);
    chk("mrst_b", 64'(rd_busy), 64'b00);
    rd(5'd11, 5'd12);
    chk("mrst_d2", rd_data, 64'h0);
    chk("mrst_b2", 64'(rd_busy), 64'b00);

    // 6b. fill the scoreboard to its max
    for (int r = 1; r <= 31; r++) begin
      issue_en   = 1'b1;
      issue_addr = 5'(r);
      tick();
    end
    idle();
    rd(5'd1, 5'd31);
    chk("full_cnt", 64'(busy_cnt), 64'd31);
    chk("full_b", 64'(rd_busy), 64'b11);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
